// File: rtl/pipeline_mem.sv
// Memory-access stage: ALU pass-through, aligned load/store requests, load extend, one result per instruction.
// Latency: 1 cycle for pass-through and misaligned ops, REQ handshake plus response for loads, REQ handshake for stores.
// Backpressure: ready only in IDLE or DONE&wb_ready; req fields hold until req_ready; wb fields hold until wb_ready.
module pipeline_mem #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  ready,
    input  logic [DATA_WIDTH-1:0] ex_res,
    input  logic [DATA_WIDTH-1:0] r2_val_mem,
    input  logic [4:0]            mem_dst_reg,
    input  logic [31:0]           next_mem_opcode,
    input  logic [2:0]            next_mem_operation_size,
    input  logic                  ecall_mem,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_write,
    output logic [DATA_WIDTH-1:0] req_wdata,
    output logic [7:0]            req_wstrb,
    input  logic                  resp_valid,
    input  logic [DATA_WIDTH-1:0] resp_data,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [4:0]            wb_dst_reg,
    output logic                  wb_ecall,
    output logic                  wb_misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t state;
    state_t state_nxt;

    logic                  accept;
    logic                  op_load;
    logic                  op_store;
    logic                  op_mem;
    logic                  misaligned;
    logic [7:0]            strb_base;

    // Fields needed after the accept cycle to shape the load response.
    logic                  is_load_q;
    logic [2:0]            size_q;
    logic [2:0]            off_q;

    logic [DATA_WIDTH-1:0] load_shift;
    logic [DATA_WIDTH-1:0] load_ext;

    assign ready     = (state == IDLE) | ((state == DONE) & wb_ready);
    assign accept    = in_valid & ready;
    assign req_valid = (state == REQ);
    assign wb_valid  = (state == DONE);

    // Decode the incoming instruction: op kind, natural-alignment fault, base byte mask.
    always_comb begin
        op_load    = (next_mem_opcode == 32'd1);
        op_store   = (next_mem_opcode == 32'd2);
        op_mem     = op_load | op_store;
        misaligned = 1'b0;
        strb_base  = 8'h00;
        case (next_mem_operation_size[1:0])
            2'd0: begin misaligned = 1'b0;          strb_base = 8'h01; end
            2'd1: begin misaligned = ex_res[0];     strb_base = 8'h03; end
            2'd2: begin misaligned = |ex_res[1:0];  strb_base = 8'h0F; end
            default: begin misaligned = |ex_res[2:0]; strb_base = 8'hFF; end
        endcase
        misaligned = misaligned & op_mem;
    end

    // Pull the addressed lane down to bit 0, truncate to the access size and extend.
    always_comb begin
        load_shift = resp_data >> {off_q, 3'b000};
        load_ext   = load_shift;
        case (size_q[1:0])
            2'd0: load_ext = size_q[2] ? {{(DATA_WIDTH-8){1'b0}}, load_shift[7:0]}
                                       : {{(DATA_WIDTH-8){load_shift[7]}}, load_shift[7:0]};
            2'd1: load_ext = size_q[2] ? {{(DATA_WIDTH-16){1'b0}}, load_shift[15:0]}
                                       : {{(DATA_WIDTH-16){load_shift[15]}}, load_shift[15:0]};
            2'd2: load_ext = size_q[2] ? {{(DATA_WIDTH-32){1'b0}}, load_shift[31:0]}
                                       : {{(DATA_WIDTH-32){load_shift[31]}}, load_shift[31:0]};
            default: load_ext = load_shift;
        endcase
    end

    // Next state: an accept always re-decodes, so DONE can chain straight into the next op.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = (op_mem & ~misaligned) ? REQ : DONE;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                REQ:  if (req_ready)  state_nxt = is_load_q ? WAIT : DONE;
                WAIT: if (resp_valid) state_nxt = DONE;
                DONE: if (wb_ready)   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register; reset abandons any in-flight request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Latch request and result fields on accept; load data lands in wb_data on response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_load_q     <= 1'b0;
            size_q        <= 3'd0;
            off_q         <= 3'd0;
            req_addr      <= '0;
            req_write     <= 1'b0;
            req_wdata     <= '0;
            req_wstrb     <= 8'h00;
            wb_data       <= '0;
            wb_dst_reg    <= 5'd0;
            wb_ecall      <= 1'b0;
            wb_misaligned <= 1'b0;
        end else if (accept) begin
            is_load_q     <= op_load;
            size_q        <= next_mem_operation_size;
            off_q         <= ex_res[2:0];
            req_addr      <= {ex_res[ADDR_WIDTH-1:3], 3'b000};
            req_write     <= op_store;
            req_wdata     <= op_store ? (r2_val_mem << {ex_res[2:0], 3'b000}) : '0;
            req_wstrb     <= op_store ? (strb_base << ex_res[2:0]) : 8'h00;
            wb_data       <= ex_res;
            wb_dst_reg    <= (op_store | misaligned) ? 5'd0 : mem_dst_reg;
            wb_ecall      <= ecall_mem;
            wb_misaligned <= misaligned;
        end else if ((state == WAIT) && resp_valid) begin
            wb_data       <= load_ext;
        end
    end

endmodule
